// File: rtl/banked_dmem_if.sv
// Request/response bus for banked_dmem: single-beat requests, fixed-latency read responses.
interface banked_dmem_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 13
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              init_done;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask,
        input  req_ready, rsp_valid, rsp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask,
        output req_ready, rsp_valid, rsp_rdata, init_done
    );
endinterface

// File: rtl/banked_dmem.sv
// Banked data memory: clears all banks after reset, then serves 1-cycle-latency reads and writes.
// Optional macro BANKED_DMEM_BYTE_MASK_EN enables per-byte write masking via req_wmask.
module banked_dmem #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_BANKS   = 8,
    parameter int unsigned BANK_ADDR_W = 10
) (
    input  logic          clk,
    input  logic          reset,
    banked_dmem_if.slave  bus
);
    localparam int unsigned SEL_W  = $clog2(NUM_BANKS);
    localparam int unsigned ADDR_W = SEL_W + BANK_ADDR_W;
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned DEPTH  = 1 << BANK_ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state;
    logic [BANK_ADDR_W-1:0] idx;
    logic [DATA_W-1:0]      mem [NUM_BANKS][DEPTH];

    logic [SEL_W-1:0]       sel;
    logic [BANK_ADDR_W-1:0] bidx;
    logic                   accept;
    logic [DATA_W-1:0]      wbits;

    assign sel           = bus.req_addr[ADDR_W-1:BANK_ADDR_W];
    assign bidx          = bus.req_addr[BANK_ADDR_W-1:0];
    assign accept        = bus.req_valid && (state == RUN);
    assign bus.req_ready = (state == RUN);
    assign bus.init_done = (state == RUN);

    // Expand the byte mask to a bit mask; without the feature every write is a full word.
`ifdef BANKED_DMEM_BYTE_MASK_EN
    for (genvar g = 0; g < MASK_W; g++) begin : g_wbits
        assign wbits[8*g +: 8] = {8{bus.req_wmask[g]}};
    end
`else
    logic unused_wmask;
    assign unused_wmask = ^bus.req_wmask;
    assign wbits        = '1;
`endif

    // Control: clear sweep counter, INIT->RUN transition, read response register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= INIT;
            idx           <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= accept && !bus.req_write;
            if (accept && !bus.req_write) begin
                bus.rsp_rdata <= mem[sel][bidx];
            end
            if (state == INIT) begin
                if (idx == '1) begin
                    state <= RUN;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // Storage: INIT zeroes one index across all banks per cycle; RUN writes only the selected bank.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                    mem[SEL_W'(b)][idx] <= '0;
                end
            end else if (accept && bus.req_write) begin
                mem[sel][bidx] <= (mem[sel][bidx] & ~wbits) | (bus.req_wdata & wbits);
            end
        end
    end
endmodule

// File: tb/tb_banked_dmem.sv
// Self-checking bench for banked_dmem: directed vector table, reset/INIT corner cases, random traffic vs a flat-memory model.
module tb_banked_dmem;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned NUM_BANKS   = 8;
    localparam int unsigned BANK_ADDR_W = 10;
    localparam int unsigned ADDR_W      = 13;
    localparam int unsigned DEPTH       = 1024;
    localparam int unsigned WORDS       = 1 << ADDR_W;

`ifdef BANKED_DMEM_BYTE_MASK_EN
    localparam logic [31:0] EXP_MASKED = 32'hAA22CC44;
`else
    localparam logic [31:0] EXP_MASKED = 32'h11223344;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    banked_dmem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    banked_dmem #(
        .DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS), .BANK_ADDR_W(BANK_ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        bit          w;
        logic [12:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic [31:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: flat word array indexed by full address, plus remaining clear cycles.
    logic [31:0] model_mem [WORDS];
    int          init_left;
    logic        exp_valid;
    logic [31:0] exp_rdata;
    vec_t        tbl [$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_write(logic [12:0] a, logic [31:0] d, logic [3:0] m);
`ifdef BANKED_DMEM_BYTE_MASK_EN
        for (int i = 0; i < 4; i++) begin
            if (m[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
        end
`else
        if (m == 4'hx) model_mem[a] = d;
        model_mem[a] = d;
`endif
    endfunction

    function automatic void add(bit w, logic [12:0] a, logic [31:0] d, logic [3:0] m, logic [31:0] e);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.m = m; v.exp = e;
        tbl.push_back(v);
    endfunction

    // One clock: drive at negedge, update model at posedge, compare at following negedge.
    task automatic step(input bit rst, input bit v, input bit w, input logic [12:0] a,
                        input logic [31:0] d, input logic [3:0] m);
        bit ready;
        reset         = rst;
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
        @(posedge clk);
        ready = (init_left == 0);
        if (rst) begin
            init_left = DEPTH;
            exp_valid = 1'b0;
            exp_rdata = '0;
            for (int i = 0; i < WORDS; i++) model_mem[i] = '0;
        end else begin
            exp_valid = 1'b0;
            if (v && ready) begin
                if (w) model_write(a, d, m);
                else begin
                    exp_valid = 1'b1;
                    exp_rdata = model_mem[a];
                end
            end
            if (init_left > 0) init_left--;
        end
        @(negedge clk);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
        check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        check("req_ready", 32'(bus.req_ready), 32'(init_left == 0));
        check("init_done", 32'(bus.init_done), 32'(init_left == 0));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Runs the clear after a reset step; optionally pokes a read at a given INIT cycle.
    task automatic wait_init(input int inject_at, output int low);
        low = 0;
        while (!bus.req_ready && low < 3000) begin
            low++;
            if (low == inject_at) step(1'b0, 1'b1, 1'b0, 13'h0003, '0, 4'hF);
            else idle();
        end
    endtask

    initial begin
        int low;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        reset         = 1'b1;
        init_left     = DEPTH;
        exp_valid     = 1'b0;
        exp_rdata     = '0;
        @(negedge clk);

        // Reset, then INIT length with a read attempted mid-clear.
        step(1'b1, 1'b0, 1'b0, '0, '0, '0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
        wait_init(500, low);
        check("init_len", 32'(low), 32'd1024);

        // Directed vector table.
        add(1'b0, 13'h0000, '0, 4'hF, 32'h0);
        add(1'b0, 13'h1FFF, '0, 4'hF, 32'h0);
        add(1'b1, 13'h0405, 32'hDEADBEEF, 4'hF, '0);
        add(1'b0, 13'h0405, '0, 4'hF, 32'hDEADBEEF);
        add(1'b0, 13'h0005, '0, 4'hF, 32'h0);
        add(1'b0, 13'h0805, '0, 4'hF, 32'h0);
        for (int k = 0; k < 8; k++) add(1'b1, 13'(k * 32'h400), 32'h11111111 * k, 4'hF, '0);
        for (int k = 0; k < 8; k++) add(1'b0, 13'(k * 32'h400), '0, 4'hF, 32'h11111111 * k);
        add(1'b1, 13'h0010, 32'hAABBCCDD, 4'hF, '0);
        add(1'b1, 13'h0010, 32'h11223344, 4'h5, '0);
        add(1'b0, 13'h0010, '0, 4'hF, EXP_MASKED);

        foreach (tbl[i]) begin
            step(1'b0, 1'b1, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].m);
            if (!tbl[i].w) begin
                check($sformatf("vec%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
                check($sformatf("vec%0d_rdata", i), bus.rsp_rdata, tbl[i].exp);
            end
        end
        idle();

        // Reset coincident with a read acceptance: response dropped, memory re-cleared.
        step(1'b0, 1'b1, 1'b1, 13'h0100, 32'h12345678, 4'hF);
        step(1'b1, 1'b1, 1'b0, 13'h0100, '0, 4'hF);
        check("rst_drop_valid", 32'(bus.rsp_valid), 32'd0);
        wait_init(0, low);
        check("reinit_len", 32'(low), 32'd1024);
        step(1'b0, 1'b1, 1'b0, 13'h0100, '0, 4'hF);
        check("reinit_0100", bus.rsp_rdata, 32'h0);

        // Randomized traffic, biased toward a small address set for read-after-write hits.
        for (int n = 0; n < 600; n++) begin
            logic [12:0] a;
            if ($urandom_range(0, 1) == 1) a = {3'($urandom_range(0, 7)), 10'($urandom_range(0, 3))};
            else a = 13'($urandom);
            step(1'b0, $urandom_range(0, 3) != 0, 1'($urandom), a, $urandom, 4'($urandom));
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
